// File: rtl/avsddac_ctrl.sv
// avsddac_ctrl: shadow-register write port and immediate or slew-limited transfer of codes to the DAC lanes.
module avsddac_ctrl #(
  parameter int WIDTH = 10,
  parameter int NCH = 4,
  parameter logic [WIDTH-1:0] RESET_CODE = '0,
  localparam int CHW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic [WIDTH-1:0]     in_code,
  input  logic                 ldac,
  input  logic                 ramp_en,
  input  logic [WIDTH-1:0]     ramp_step,
  output logic [NCH*WIDTH-1:0] dac_code,
  output logic                 busy,
  output logic                 upd_done,
  output logic                 wr_err
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] target_q [NCH];
  logic [WIDTH-1:0] target_d [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic [WIDTH-1:0] step_q, step_d;
  logic ldac_pend_q, ldac_pend_d;
  logic in_ready_q, busy_q, busy_d, upd_done_q, upd_done_d, wr_err_q, wr_err_d;
  logic wr, all_eq;
  // The difference is taken one bit wider so the magnitude test never wraps.
  function automatic logic [WIDTH-1:0] ramp_next(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] t,
                                                 input logic [WIDTH-1:0] s);
    logic signed [WIDTH:0] d;
    logic [WIDTH:0] mag;
    d = $signed({1'b0, t}) - $signed({1'b0, a});
    mag = d[WIDTH] ? -d : d;
    return (mag <= {1'b0, s}) ? t : d[WIDTH] ? a - s : a + s;
  endfunction
  always_comb begin
    wr = in_valid & in_ready_q;
    shadow_d = shadow_q;
    target_d = target_q;
    active_d = active_q;
    step_d = step_q;
    state_d = state_q;
    ldac_pend_d = ldac_pend_q;
    busy_d = busy_q;
    upd_done_d = 1'b0;
    wr_err_d = wr && (32'(in_ch) >= NCH);
    all_eq = 1'b1;
    for (int i = 0; i < NCH; i++) if (wr && 32'(in_ch) == i) shadow_d[i] = in_code;
    if (state_q == IDLE) begin
      if (ldac || ldac_pend_q) begin
        target_d = shadow_d;
        ldac_pend_d = 1'b0;
        if (ramp_en) begin
          step_d = (ramp_step == '0) ? WIDTH'(1) : ramp_step;
          state_d = RAMP;
          busy_d = 1'b1;
        end else begin
          active_d = shadow_d;
          upd_done_d = 1'b1;
        end
      end
    end else begin
      ldac_pend_d = ldac_pend_q | ldac;
      for (int i = 0; i < NCH; i++) begin
        active_d[i] = ramp_next(active_q[i], target_q[i], step_q);
        all_eq = all_eq & (active_d[i] == target_q[i]);
      end
      if (all_eq) begin
        state_d = IDLE;
        busy_d = 1'b0;
        upd_done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: RESET_CODE};
      target_q <= '{default: RESET_CODE};
      active_q <= '{default: RESET_CODE};
      step_q <= WIDTH'(1);
      state_q <= IDLE;
      ldac_pend_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
      upd_done_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      target_q <= target_d;
      active_q <= active_d;
      step_q <= step_d;
      state_q <= state_d;
      ldac_pend_q <= ldac_pend_d;
      in_ready_q <= 1'b1;
      busy_q <= busy_d;
      upd_done_q <= upd_done_d;
      wr_err_q <= wr_err_d;
    end
  end
  for (genvar g = 0; g < NCH; g++) assign dac_code[g*WIDTH +: WIDTH] = active_q[g];
  assign in_ready = in_ready_q;
  assign busy = busy_q;
  assign upd_done = upd_done_q;
  assign wr_err = wr_err_q;
endmodule

// File: tb/tb_avsddac_ctrl.sv
// tb_avsddac_ctrl: directed scenarios for avsddac_ctrl with hand-computed lane values.
module tb_avsddac_ctrl;
  logic clk = 0, rst = 1;
  logic in_valid = 0, ldac = 0, ramp_en = 0;
  logic [1:0] in_ch = '0;
  logic [9:0] in_code = '0, ramp_step = '0;
  logic in_ready, busy, upd_done, wr_err;
  logic [39:0] dac_code;
  logic in_ready3, busy3, upd3, wr_err3;
  logic [29:0] dac3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  avsddac_ctrl #(.WIDTH(10), .NCH(4)) dut (
    .CLK(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_code(in_code),
    .ldac(ldac), .ramp_en(ramp_en), .ramp_step(ramp_step), .dac_code(dac_code), .busy(busy),
    .upd_done(upd_done), .wr_err(wr_err));
  avsddac_ctrl #(.WIDTH(10), .NCH(3)) dut3 (
    .CLK(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_ch(in_ch), .in_code(in_code),
    .ldac(ldac), .ramp_en(ramp_en), .ramp_step(ramp_step), .dac_code(dac3), .busy(busy3),
    .upd_done(upd3), .wr_err(wr_err3));
  function automatic logic [9:0] lane(input int i);
    return dac_code[i*10 +: 10];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] ch, input logic [9:0] c);
    in_valid = 1; in_ch = ch; in_code = c;
    tick;
    in_valid = 0;
  endtask
  task automatic test_reset;
    #12;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (dac_code !== 40'h0) begin failures++; $display("FAIL reset_dac got %h want 0", dac_code); end
    checks++; if ({busy, upd_done, wr_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {busy, upd_done, wr_err}); end
    rst = 0;
    tick;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got %b want 1", in_ready); end
  endtask
  task automatic test_immediate;
    wr(2, 10'h155);
    checks++; if (dac_code !== 40'h0) begin failures++; $display("FAIL shadow_hidden got %h want 0", dac_code); end
    ldac = 1; ramp_en = 0;
    tick;
    ldac = 0;
    checks++; if (dac_code !== {10'h0, 10'h155, 10'h0, 10'h0}) begin failures++; $display("FAIL imm_load got %h want lane2=155", dac_code); end
    checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL imm_upd got %b want 1", upd_done); end
    tick;
    checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL imm_upd_pulse got %b want 0", upd_done); end
  endtask
  task automatic test_ramp;
    int e0, e1;
    wr(1, 10'd1000);
    ldac = 1;
    tick;
    ldac = 0;
    wr(0, 10'd1023);
    wr(1, 10'd0);
    ldac = 1; ramp_en = 1; ramp_step = 10'd100;
    tick;
    ldac = 0; ramp_en = 0;
    checks++; if (busy !== 1'b1 || lane(0) !== 10'd0 || lane(1) !== 10'd1000) begin failures++; $display("FAIL ramp_start got busy=%b l0=%0d l1=%0d want 1/0/1000", busy, lane(0), lane(1)); end
    for (int n = 1; n <= 11; n++) begin
      tick;
      e0 = (n * 100 > 1023) ? 1023 : n * 100;
      e1 = (1000 - n * 100 < 0) ? 0 : 1000 - n * 100;
      checks++; if (lane(0) !== 10'(e0) || lane(1) !== 10'(e1)) begin failures++; $display("FAIL ramp_step%0d got %0d/%0d want %0d/%0d", n, lane(0), lane(1), e0, e1); end
      checks++; if (busy !== (n < 11) || upd_done !== (n == 11)) begin failures++; $display("FAIL ramp_flags%0d got busy=%b upd=%b want %b/%b", n, busy, upd_done, n < 11, n == 11); end
    end
    checks++; if (lane(2) !== 10'h155) begin failures++; $display("FAIL ramp_lane2 got %h want 155", lane(2)); end
    tick;
    checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL ramp_upd_pulse got %b want 0", upd_done); end
  endtask
  task automatic test_write_through;
    in_valid = 1; in_ch = 1; in_code = 10'd7; ldac = 1; ramp_en = 0;
    tick;
    in_valid = 0; ldac = 0;
    checks++; if (lane(1) !== 10'd7 || upd_done !== 1'b1) begin failures++; $display("FAIL write_through got l1=%0d upd=%b want 7/1", lane(1), upd_done); end
  endtask
  task automatic test_pending;
    wr(3, 10'd300);
    ldac = 1; ramp_en = 1; ramp_step = 10'd100;
    tick;
    ldac = 0;
    checks++; if (busy !== 1'b1 || lane(3) !== 10'd0) begin failures++; $display("FAIL pend_start got busy=%b l3=%0d want 1/0", busy, lane(3)); end
    ldac = 1; in_valid = 1; in_ch = 3; in_code = 10'd5;
    tick;
    ldac = 0; in_valid = 0; ramp_en = 0;
    checks++; if (lane(3) !== 10'd100 || busy !== 1'b1) begin failures++; $display("FAIL pend_k1 got l3=%0d busy=%b want 100/1", lane(3), busy); end
    tick;
    checks++; if (lane(3) !== 10'd200) begin failures++; $display("FAIL pend_k2 got l3=%0d want 200", lane(3)); end
    tick;
    checks++; if (lane(3) !== 10'd300 || busy !== 1'b0 || upd_done !== 1'b1) begin failures++; $display("FAIL pend_end got l3=%0d busy=%b upd=%b want 300/0/1", lane(3), busy, upd_done); end
    tick;
    checks++; if (lane(3) !== 10'd5 || upd_done !== 1'b1 || lane(1) !== 10'd7) begin failures++; $display("FAIL pend_second got l3=%0d upd=%b l1=%0d want 5/1/7", lane(3), upd_done, lane(1)); end
    tick;
    checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL pend_upd_pulse got %b want 0", upd_done); end
  endtask
  task automatic test_step0;
    wr(0, 10'd1020);
    ldac = 1; ramp_en = 1; ramp_step = 10'd0;
    tick;
    ldac = 0; ramp_en = 0;
    for (int n = 1; n <= 3; n++) begin
      tick;
      checks++; if (lane(0) !== 10'(1023 - n) || busy !== (n < 3) || upd_done !== (n == 3)) begin failures++; $display("FAIL step0_%0d got l0=%0d busy=%b upd=%b want %0d/%b/%b", n, lane(0), busy, upd_done, 1023 - n, n < 3, n == 3); end
    end
  endtask
  task automatic test_equal;
    ldac = 1; ramp_en = 1; ramp_step = 10'd50;
    tick;
    ldac = 0; ramp_en = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL equal_busy got %b want 1", busy); end
    tick;
    checks++; if (busy !== 1'b0 || upd_done !== 1'b1 || lane(0) !== 10'd1020) begin failures++; $display("FAIL equal_done got busy=%b upd=%b l0=%0d want 0/1/1020", busy, upd_done, lane(0)); end
  endtask
  task automatic test_wr_err;
    wr(3, 10'd9);
    checks++; if (wr_err3 !== 1'b1 || wr_err !== 1'b0) begin failures++; $display("FAIL wr_err got nch3=%b nch4=%b want 1/0", wr_err3, wr_err); end
    tick;
    checks++; if (wr_err3 !== 1'b0) begin failures++; $display("FAIL wr_err_pulse got %b want 0", wr_err3); end
    ldac = 1;
    tick;
    ldac = 0;
    checks++; if (dac3 !== {10'h155, 10'd7, 10'd1020}) begin failures++; $display("FAIL wr_err_noshadow got %h want %h", dac3, {10'h155, 10'd7, 10'd1020}); end
    checks++; if (lane(3) !== 10'd9) begin failures++; $display("FAIL nch4_lane3 got %0d want 9", lane(3)); end
  endtask
  task automatic test_reset_mid_ramp;
    wr(0, 10'd0);
    ldac = 1; ramp_en = 1; ramp_step = 10'd1;
    tick;
    ldac = 0; ramp_en = 0;
    tick;
    checks++; if (busy !== 1'b1 || lane(0) !== 10'd1019) begin failures++; $display("FAIL mid_ramp got busy=%b l0=%0d want 1/1019", busy, lane(0)); end
    #2 rst = 1;
    #1;
    checks++; if (dac_code !== 40'h0 || busy !== 1'b0 || dac3 !== 30'h0) begin failures++; $display("FAIL async_reset got dac=%h busy=%b want 0/0", dac_code, busy); end
    #10 rst = 0;
    for (int n = 0; n < 3; n++) begin
      tick;
      checks++; if (upd_done !== 1'b0 || busy !== 1'b0 || dac_code !== 40'h0) begin failures++; $display("FAIL post_reset%0d got upd=%b busy=%b dac=%h want 0/0/0", n, upd_done, busy, dac_code); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
  endtask
  initial begin
    test_reset;
    test_immediate;
    test_ramp;
    test_write_through;
    test_pending;
    test_step0;
    test_equal;
    test_wr_err;
    test_reset_mid_ramp;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
